// File: rtl/fp_status_checker.sv
// ---------------------------------------------------------------------------
// fp_status_checker
//
// Synthesizable run-time consistency checker for the status byte of a
// floating-point multiplier. It runs alongside a fixed-latency datapath. On
// every result cycle it evaluates six rules R0..R5. It keeps sticky per-rule
// error flags and saturating check and violation counters, and it captures
// the rule index and check number of the first violation.
//
// Ports:
//   i_clk            clock, all logic on the rising edge
//   i_rst            synchronous reset, active-high (also flushes NaN pipe)
//   i_in_valid       i_a / i_b carry a new operand pair
//   i_a, i_b         operands, {sign, exponent, mantissa}
//   i_out_valid      i_z / i_status carry a result
//   i_z              result word
//   i_status         [0]zero [1]inf [2]nan [3]tiny [4]huge [5]inexact
//                    [6]unused [7]divbytwo
//   i_clr            synchronous clear of counters, flags and capture regs
//   o_err_vec        sticky per-rule violation flags, bit i = rule Ri
//   o_err_any        OR of o_err_vec
//   o_chk_cnt        number of checked result cycles, saturating
//   o_viol_cnt       number of checked cycles with any violation, saturating
//   o_first_err_rule lowest failing rule in the first violating cycle, 7=none
//   o_first_err_at   o_chk_cnt value (pre-increment) in the first violation
// ---------------------------------------------------------------------------
module fp_status_checker #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    input  logic [EXP_W+MAN_W:0]     i_a,
    input  logic [EXP_W+MAN_W:0]     i_b,
    input  logic                     i_out_valid,
    input  logic [EXP_W+MAN_W:0]     i_z,
    input  logic [7:0]               i_status,
    input  logic                     i_clr,
    output logic [5:0]               o_err_vec,
    output logic                     o_err_any,
    output logic [CNT_W-1:0]         o_chk_cnt,
    output logic [CNT_W-1:0]         o_viol_cnt,
    output logic [2:0]               o_first_err_rule,
    output logic [CNT_W-1:0]         o_first_err_at
);

    localparam logic [EXP_W-1:0] EXP_ONES   = '1;
    localparam logic [EXP_W-1:0] EXP_ONESM1 = EXP_ONES - EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_ZERO   = '0;
    localparam logic [EXP_W-1:0] EXP_ONE    = EXP_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // Delay line of {valid, NaN prediction}. Index LAT-1 lines up with the
    // result slot of the operands that were pushed LAT cycles earlier.
    logic [LAT-1:0]   r_pipe_v;
    logic [LAT-1:0]   r_pipe_p;

    logic [5:0]       r_err_vec;
    logic             r_err_any;
    logic [CNT_W-1:0] r_chk_cnt;
    logic [CNT_W-1:0] r_viol_cnt;
    logic [2:0]       r_first_rule;
    logic [CNT_W-1:0] r_first_at;

    logic [EXP_W-1:0] w_aexp;
    logic [EXP_W-1:0] w_bexp;
    logic [EXP_W-1:0] w_zexp;
    logic             w_pred;
    logic [5:0]       w_rules;
    logic             w_viol;
    logic [2:0]       w_lowest;
    logic [5:0]       w_err_nxt;
    logic [CNT_W-1:0] w_chk_nxt;
    logic [CNT_W-1:0] w_viol_nxt;

    // Sign and mantissa bits play no part in any rule.
    logic w_unused;
    assign w_unused = ^{i_a[EXP_W+MAN_W], i_a[MAN_W-1:0],
                        i_b[EXP_W+MAN_W], i_b[MAN_W-1:0],
                        i_z[EXP_W+MAN_W], i_z[MAN_W-1:0]};

    assign w_aexp = i_a[EXP_W+MAN_W-1:MAN_W];
    assign w_bexp = i_b[EXP_W+MAN_W-1:MAN_W];
    assign w_zexp = i_z[EXP_W+MAN_W-1:MAN_W];

    // A zero times an infinity must produce NaN. Predict it on the input side.
    assign w_pred = i_in_valid &&
                    (((w_aexp == EXP_ZERO) && (w_bexp == EXP_ONES)) ||
                     ((w_aexp == EXP_ONES) && (w_bexp == EXP_ZERO)));

    // Rule evaluation and lowest-index selection.
    always_comb begin
        w_rules  = 6'd0;
        w_lowest = 3'd7;
        if (i_out_valid) begin
            // x & (x-1) clears the lowest set bit; non-zero means >1 bit set.
            w_rules[0] = |(i_status & (i_status - 8'd1));
            w_rules[1] = i_status[0] && (w_zexp != EXP_ZERO);
            w_rules[2] = i_status[1] && (w_zexp != EXP_ONES);
            w_rules[3] = i_status[4] && (w_zexp != EXP_ONES) && (w_zexp != EXP_ONESM1);
            w_rules[4] = i_status[3] && (w_zexp != EXP_ZERO) && (w_zexp != EXP_ONE);
        end else begin
            w_rules[4:0] = 5'd0;
        end
        // A predicted NaN must appear as a NaN result in its slot. A missing
        // result in that slot also counts as a failure.
        w_rules[5] = r_pipe_v[LAT-1] && r_pipe_p[LAT-1] &&
                     (!i_out_valid || !i_status[2]);
        casez (w_rules)
            6'b?????1: w_lowest = 3'd0;
            6'b????10: w_lowest = 3'd1;
            6'b???100: w_lowest = 3'd2;
            6'b??1000: w_lowest = 3'd3;
            6'b?10000: w_lowest = 3'd4;
            6'b100000: w_lowest = 3'd5;
            default:   w_lowest = 3'd7;
        endcase
    end

    assign w_viol     = |w_rules;
    assign w_err_nxt  = r_err_vec | w_rules;
    assign w_chk_nxt  = (i_out_valid && (r_chk_cnt != CNT_MAX)) ?
                        (r_chk_cnt + CNT_W'(1)) : r_chk_cnt;
    assign w_viol_nxt = (w_viol && (r_viol_cnt != CNT_MAX)) ?
                        (r_viol_cnt + CNT_W'(1)) : r_viol_cnt;

    // NaN prediction delay line. It is flushed by reset only, so it keeps
    // advancing through a clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe_v <= '0;
            r_pipe_p <= '0;
        end else begin
            r_pipe_v[0] <= i_in_valid;
            r_pipe_p[0] <= w_pred;
            for (int i = 1; i < LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_p[i] <= r_pipe_p[i-1];
            end
        end
    end

    // Counters, sticky flags and first-failure capture. Clear wins over update.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_err_vec    <= 6'd0;
            r_err_any    <= 1'b0;
            r_chk_cnt    <= '0;
            r_viol_cnt   <= '0;
            r_first_rule <= 3'd7;
            r_first_at   <= '0;
        end else begin
            r_err_vec  <= w_err_nxt;
            r_err_any  <= |w_err_nxt;
            r_chk_cnt  <= w_chk_nxt;
            r_viol_cnt <= w_viol_nxt;
            if (w_viol && (r_first_rule == 3'd7)) begin
                r_first_rule <= w_lowest;
                r_first_at   <= r_chk_cnt;
            end else begin
                r_first_rule <= r_first_rule;
                r_first_at   <= r_first_at;
            end
        end
    end

    assign o_err_vec        = r_err_vec;
    assign o_err_any        = r_err_any;
    assign o_chk_cnt        = r_chk_cnt;
    assign o_viol_cnt       = r_viol_cnt;
    assign o_first_err_rule = r_first_rule;
    assign o_first_err_at   = r_first_at;

endmodule

// File: tb/tb_fp_status_checker.sv
// ---------------------------------------------------------------------------
// tb_fp_status_checker
//
// Self-checking bench for fp_status_checker (EXP_W=8, MAN_W=23, LAT=2,
// CNT_W=4, so saturation is reachable). A per-cycle reference model derives
// the expected outputs from the rule definitions. The model keeps a history
// of NaN predictions and reset cycles indexed by cycle number. The bench runs
// the directed scenarios first and then randomized traffic.
// ---------------------------------------------------------------------------
module tb_fp_status_checker;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int LAT     = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int HIST    = 8192;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, out_valid;
    logic [31:0] a, b, z;
    logic [7:0]  status;
    logic [5:0]  err_vec;
    logic        err_any;
    logic [CNT_W-1:0] chk_cnt, viol_cnt, first_err_at;
    logic [2:0]  first_err_rule;

    always #5 clk = ~clk;

    fp_status_checker #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_a(a), .i_b(b),
        .i_out_valid(out_valid), .i_z(z), .i_status(status), .i_clr(clr),
        .o_err_vec(err_vec), .o_err_any(err_any), .o_chk_cnt(chk_cnt),
        .o_viol_cnt(viol_cnt), .o_first_err_rule(first_err_rule),
        .o_first_err_at(first_err_at)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    bit   hist_pred [HIST];
    bit   hist_rst  [HIST];
    logic [5:0] m_err = 6'd0;
    int   m_chk  = 0;
    int   m_viol = 0;
    int   m_fr   = 7;
    int   m_fa   = 0;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int expo(input logic [31:0] v);
        return int'((v >> 23) & 32'd255);
    endfunction

    function automatic logic [31:0] mkword(input int e);
        logic [31:0] w;
        w = $urandom;
        w[30:23] = 8'(e);
        return w;
    endfunction

    // Drive one cycle, advance the model and compare every output.
    task automatic step(input bit rst_i, input bit clr_i, input bit iv, input logic [31:0] a_i,
                        input logic [31:0] b_i, input bit ov, input logic [31:0] z_i,
                        input logic [7:0] st_i);
        bit [5:0] r;
        bit alive;
        int ze;
        int low;
        rst = rst_i; clr = clr_i; in_valid = iv; a = a_i; b = b_i;
        out_valid = ov; z = z_i; status = st_i;

        ze = expo(z_i);
        hist_pred[cyc] = iv && ((expo(a_i) == 0 && expo(b_i) == 255) ||
                                (expo(a_i) == 255 && expo(b_i) == 0));
        hist_rst[cyc]  = rst_i;
        r = 6'd0;
        if (ov) begin
            r[0] = $countones(st_i) > 1;
            r[1] = st_i[0] && ze != 0;
            r[2] = st_i[1] && ze != 255;
            r[3] = st_i[4] && !(ze == 255 || ze == 254);
            r[4] = st_i[3] && !(ze == 0 || ze == 1);
        end
        if (cyc >= LAT && hist_pred[cyc-LAT]) begin
            // Any reset from the push cycle onward discards the prediction.
            alive = 1'b1;
            for (int k = cyc - LAT; k < cyc; k++)
                if (hist_rst[k]) alive = 1'b0;
            r[5] = alive && (!ov || !st_i[2]);
        end

        if (rst_i || clr_i) begin
            m_err = 6'd0; m_chk = 0; m_viol = 0; m_fr = 7; m_fa = 0;
        end else begin
            if (r != 6'd0) begin
                if (m_fr == 7) begin
                    low = 7;
                    for (int i = 5; i >= 0; i--)
                        if (r[i]) low = i;
                    m_fr = low;
                    m_fa = m_chk;
                end
                if (m_viol < CNT_MAX) m_viol++;
                m_err = m_err | r;
            end
            if (ov && m_chk < CNT_MAX) m_chk++;
        end

        @(posedge clk);
        #1;
        cyc++;
        check_eq("err_vec",   32'(err_vec),        32'(m_err));
        check_eq("err_any",   32'(err_any),        32'(|m_err));
        check_eq("chk_cnt",   32'(chk_cnt),        32'(m_chk));
        check_eq("viol_cnt",  32'(viol_cnt),       32'(m_viol));
        check_eq("first_rule",32'(first_err_rule), 32'(m_fr));
        check_eq("first_at",  32'(first_err_at),   32'(m_fa));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 8'h00);
    endtask

    task automatic do_clr();
        step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 8'h00);
    endtask

    task automatic chk_res(input logic [31:0] z_i, input logic [7:0] st_i);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, z_i, st_i);
    endtask

    task automatic nan_op();
        step(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h7F80_0000, 1'b0, 32'd0, 8'h00);
    endtask

    initial begin
        int sel;
        logic [7:0] st;
        logic [31:0] ra, rb, rz;
        int exps [5];
        exps = '{0, 1, 254, 255, 128};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_valid = 1'b0;
        a = 32'd0; b = 32'd0; z = 32'd0; status = 8'h00;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 8'h00);
        check_eq("rst_first_rule", 32'(first_err_rule), 32'd7);

        // Ten clean zero results
        for (int i = 0; i < 10; i++) chk_res(32'h0000_0000, 8'h01);
        check_eq("clean_chk", 32'(chk_cnt), 32'd10);
        check_eq("clean_err", 32'(err_vec), 32'd0);

        // Three clean, then zero+inf on an infinity exponent: R0 and R1
        do_clr();
        for (int i = 0; i < 3; i++) chk_res(32'h0000_0000, 8'h01);
        chk_res(32'h7F80_0000, 8'h03);
        check_eq("multi_err_vec", 32'(err_vec), 32'h03);
        check_eq("multi_viol", 32'(viol_cnt), 32'd1);
        check_eq("multi_rule", 32'(first_err_rule), 32'd0);
        check_eq("multi_at", 32'(first_err_at), 32'd3);
        idle();

        // Huge and tiny boundaries
        do_clr();
        chk_res({1'b0, 8'hFE, 23'd5}, 8'h10);
        check_eq("huge_ok", 32'(err_vec), 32'd0);
        chk_res({1'b0, 8'hFD, 23'd5}, 8'h10);
        check_eq("huge_bad", 32'(err_vec[3]), 32'd1);
        chk_res({1'b0, 8'h01, 23'd5}, 8'h08);
        check_eq("tiny_ok", 32'(err_vec[4]), 32'd0);
        chk_res({1'b0, 8'h02, 23'd5}, 8'h08);
        check_eq("tiny_bad", 32'(err_vec[4]), 32'd1);

        // NaN prediction path, LAT=2
        do_clr();
        nan_op(); idle(); chk_res(32'h7FC0_0000, 8'h04);
        check_eq("nan_ok", 32'(err_vec), 32'd0);
        nan_op(); idle(); chk_res(32'h7FC0_0000, 8'h00);
        check_eq("nan_status0", 32'(err_vec[5]), 32'd1);
        do_clr();
        nan_op(); idle(); idle();
        check_eq("nan_dropped", 32'(err_vec[5]), 32'd1);

        // Saturation, then clear in a violating cycle
        do_clr();
        for (int i = 0; i < 20; i++) chk_res(32'h0000_0000, 8'hFF);
        check_eq("sat_chk", 32'(chk_cnt), 32'd15);
        check_eq("sat_viol", 32'(viol_cnt), 32'd15);
        step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 8'hFF);
        check_eq("clr_viol", 32'(viol_cnt), 32'd0);
        check_eq("clr_rule", 32'(first_err_rule), 32'd7);

        // Reset between a NaN operand and its slot
        nan_op();
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 8'h00);
        chk_res(32'h0000_0000, 8'h00);
        check_eq("rst_flush", 32'(err_vec), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 2);
            ra = mkword(sel == 0 ? 0 : sel == 1 ? 255 : int'($urandom_range(0, 255)));
            sel = $urandom_range(0, 2);
            rb = mkword(sel == 0 ? 0 : sel == 1 ? 255 : int'($urandom_range(0, 255)));
            rz = mkword(exps[$urandom_range(0, 4)]);
            sel = $urandom_range(0, 3);
            if (sel == 0)      st = 8'h00;
            else if (sel == 3) st = 8'($urandom);
            else begin
                st = 8'h01;
                st = st << $urandom_range(0, 7);
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 1) == 1, ra, rb,
                 $urandom_range(0, 9) < 6, rz, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
